// File: rtl/fp64_mem_sequencer_pkg.sv
// Shared types and constants for the FLD/FSD two-beat memory sequencer.
package fp64_mem_sequencer_pkg;

   localparam int unsigned XLEN                = 32;
   localparam int unsigned FP64_W              = 64;
   localparam int unsigned BWE_W               = 4;
   localparam int unsigned FP64_HI_WORD_OFFSET = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LD_HI   = 2'd1,
      LD_DONE = 2'd2,
      ST_DONE = 2'd3
   } fp64_seq_state_e;

endpackage

// File: rtl/fp64_mem_sequencer_if.sv
// Pipeline/arbiter-facing signal bundle of the FP64 memory sequencer.
interface fp64_mem_sequencer_if #(
   parameter int unsigned XLEN = fp64_mem_sequencer_pkg::XLEN
);
   logic            i_fld_req;
   logic            i_fsd_req;
   logic [XLEN-1:0] i_addr;
   logic [XLEN-1:0] i_fsd_data_hi;
   logic [XLEN-1:0] i_mem_rd_data;
   logic            i_hold;
   logic            i_flush;

   logic            o_fp_mem_addr_override;
   logic [XLEN-1:0] o_fp_mem_address;
   logic [XLEN-1:0] o_fp_mem_write_data;
   logic [3:0]      o_fp_mem_byte_write_enable;
   logic            o_stall;
   logic [63:0]     o_fld_data;
   logic            o_fld_valid;
   logic            o_busy;

   // Pipeline side: drives requests, consumes sequencer results.
   modport master (
      output i_fld_req, i_fsd_req, i_addr, i_fsd_data_hi, i_mem_rd_data, i_hold, i_flush,
      input  o_fp_mem_addr_override, o_fp_mem_address, o_fp_mem_write_data,
             o_fp_mem_byte_write_enable, o_stall, o_fld_data, o_fld_valid, o_busy
   );

   // Sequencer side.
   modport slave (
      input  i_fld_req, i_fsd_req, i_addr, i_fsd_data_hi, i_mem_rd_data, i_hold, i_flush,
      output o_fp_mem_addr_override, o_fp_mem_address, o_fp_mem_write_data,
             o_fp_mem_byte_write_enable, o_stall, o_fld_data, o_fld_valid, o_busy
   );

endinterface

// File: rtl/fp64_mem_sequencer.sv
// Steals the data memory port for one cycle after an FLD/FSD low-word access to move
// the high word at A+4, stalling the pipeline for that cycle and assembling FLD results.
module fp64_mem_sequencer #(
   parameter int unsigned XLEN = fp64_mem_sequencer_pkg::XLEN
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   fp64_mem_sequencer_if.slave  bus
);
   import fp64_mem_sequencer_pkg::*;

   fp64_seq_state_e state_q;
   fp64_seq_state_e state_d;
   logic [XLEN-1:0] lo_q;
   logic [XLEN-1:0] hi_q;

   logic start_ld;
   logic start_st;

   logic            override_c;
   logic [XLEN-1:0] address_c;
   logic [XLEN-1:0] write_data_c;
   logic [3:0]      bwe_c;
   logic            stall_c;
   logic [63:0]     fld_data_c;
   logic            fld_valid_c;
   logic            busy_c;

   // Starts only from IDLE so a held request cannot retrigger; flush and FLD take priority.
   assign start_ld = (state_q == IDLE) && bus.i_fld_req && !bus.i_flush;
   assign start_st = (state_q == IDLE) && bus.i_fsd_req && !bus.i_fld_req && !bus.i_flush;

   // State register plus captured low/high load words.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= IDLE;
         lo_q    <= '0;
         hi_q    <= '0;
      end else begin
         state_q <= state_d;
         if (start_ld) begin
            lo_q <= bus.i_mem_rd_data;
         end
         if (state_q == LD_HI) begin
            hi_q <= bus.i_mem_rd_data;
         end
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (start_ld) begin
               state_d = LD_HI;
            end else if (start_st) begin
               state_d = ST_DONE;
            end
         end
         LD_HI: begin
            if (bus.i_flush || !bus.i_hold) begin
               state_d = IDLE;
            end else begin
               state_d = LD_DONE;
            end
         end
         LD_DONE, ST_DONE: begin
            if (bus.i_flush || !bus.i_hold) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs; bus-side outputs deliberately ignore i_hold to keep the stall network acyclic.
   always_comb begin
      override_c   = 1'b0;
      address_c    = '0;
      write_data_c = '0;
      bwe_c        = 4'b0000;
      stall_c      = 1'b0;
      fld_data_c   = '0;
      fld_valid_c  = 1'b0;
      busy_c       = (state_q != IDLE);

      if (start_ld || start_st) begin
         override_c = 1'b1;
         stall_c    = 1'b1;
         address_c  = XLEN'(bus.i_addr + XLEN'(FP64_HI_WORD_OFFSET));
      end
      if (start_st) begin
         write_data_c = bus.i_fsd_data_hi;
         bwe_c        = 4'b1111;
      end

      unique case (state_q)
         LD_HI: begin
            fld_data_c  = 64'({bus.i_mem_rd_data, lo_q});
            fld_valid_c = !bus.i_flush;
         end
         LD_DONE: begin
            fld_data_c  = 64'({hi_q, lo_q});
            fld_valid_c = !bus.i_flush;
         end
         default: begin
            fld_data_c  = '0;
            fld_valid_c = 1'b0;
         end
      endcase
   end

   // Everything is held quiet while reset is asserted.
   always_comb begin
      bus.o_fp_mem_addr_override     = override_c  && !i_rst;
      bus.o_fp_mem_address           = i_rst ? '0 : address_c;
      bus.o_fp_mem_write_data        = i_rst ? '0 : write_data_c;
      bus.o_fp_mem_byte_write_enable = i_rst ? 4'b0000 : bwe_c;
      bus.o_stall                    = stall_c     && !i_rst;
      bus.o_fld_data                 = i_rst ? '0 : fld_data_c;
      bus.o_fld_valid                = fld_valid_c && !i_rst;
      bus.o_busy                     = busy_c      && !i_rst;
   end

`ifdef FORMAL
   always @(posedge i_clk) begin
      if (!i_rst) begin
         assume (!(bus.i_fld_req && bus.i_fsd_req));
         assert (!bus.o_stall || (state_q == IDLE));
         assert ((bus.o_fp_mem_byte_write_enable == 4'b0000) || bus.o_fp_mem_addr_override);
         assert ((bus.o_fp_mem_byte_write_enable == 4'b0000) || start_st);
         assert (!(bus.o_fld_valid && bus.o_stall));
      end
   end
`endif

endmodule
